// File: rtl/button_debounce_if.sv
// button_debounce_if: pin-side and event-side signals of the button front end.
//   iButtonRaw      raw asynchronous button pins, 1 = pressed
//   oButtonLevel    debounced level per channel
//   oButtonPress    one-cycle pulse on debounced 0->1
//   oButtonRelease  one-cycle pulse on debounced 1->0
//   oButtonLong     one-cycle pulse once per press after the long-press time
//   oButtonRepeat   one-cycle auto-repeat pulses while held past long-press
// Modports: master = board/consumer side, slave = button_debounce.
interface button_debounce_if #(
   parameter int unsigned P_BUTTON_WIDTH = 5
);
   logic [P_BUTTON_WIDTH-1:0] iButtonRaw;
   logic [P_BUTTON_WIDTH-1:0] oButtonLevel;
   logic [P_BUTTON_WIDTH-1:0] oButtonPress;
   logic [P_BUTTON_WIDTH-1:0] oButtonRelease;
   logic [P_BUTTON_WIDTH-1:0] oButtonLong;
   logic [P_BUTTON_WIDTH-1:0] oButtonRepeat;

   modport master (
      output iButtonRaw,
      input  oButtonLevel, oButtonPress, oButtonRelease, oButtonLong, oButtonRepeat
   );

   modport slave (
      input  iButtonRaw,
      output oButtonLevel, oButtonPress, oButtonRelease, oButtonLong, oButtonRepeat
   );
endinterface

// File: rtl/button_debounce.sv
// button_debounce: per-channel synchroniser, debouncer, press/release/long-press
// pulse generator with optional auto-repeat.
// Ports:
//   iClk  system clock
//   iRst  synchronous active-high reset, clears every flop
//   bus   button_debounce_if.slave (raw pins in, level and pulses out)
// Optional feature: define BUTTON_DEBOUNCE_AUTOREPEAT_EN to build the repeat
// counters; otherwise oButtonRepeat is tied to 0.
module button_debounce #(
   parameter int unsigned P_BUTTON_WIDTH    = 5,
   parameter int unsigned P_DEBOUNCE_CYCLES = 16,
   parameter int unsigned P_LONG_CYCLES     = 1000,
   parameter int unsigned P_REPEAT_CYCLES   = 250
) (
   input  logic             iClk,
   input  logic             iRst,
   button_debounce_if.slave bus
);
   localparam int unsigned W  = P_BUTTON_WIDTH;
   localparam int unsigned DW = $clog2(P_DEBOUNCE_CYCLES + 1);
   localparam int unsigned HW = $clog2(P_LONG_CYCLES + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HELD = 2'd1,
      LONG = 2'd2
   } state_t;

   // Reject degenerate parameterisations at elaboration.
   if (P_BUTTON_WIDTH < 1 || P_DEBOUNCE_CYCLES < 1 ||
       P_LONG_CYCLES < 1 || P_REPEAT_CYCLES < 1) begin : g_param_check
      $error("button_debounce: all parameters must be >= 1");
   end

   logic [W-1:0]  sync1, sync2, level;
   logic [W-1:0]  press_q, rel_q, long_q;
   logic [DW-1:0] db_cnt   [W];
   logic [HW-1:0] hold_cnt [W];
   state_t        state    [W];

   logic [W-1:0]  mismatch, flip, long_nxt;
   logic [DW-1:0] db_nxt    [W];
   logic [HW-1:0] hold_nxt  [W];
   state_t        state_nxt [W];

   // Debounce counting, hold counting and per-channel next state.
   always_comb begin
      mismatch = '0;
      flip     = '0;
      long_nxt = '0;
      for (int i = 0; i < int'(W); i++) begin
         db_nxt[i]    = '0;
         hold_nxt[i]  = '0;
         state_nxt[i] = state[i];

         mismatch[i] = sync2[i] ^ level[i];
         // Flip on the cycle the counter has seen D-1 prior mismatching cycles.
         flip[i] = mismatch[i] && (db_cnt[i] == DW'(P_DEBOUNCE_CYCLES - 1));
         if (mismatch[i] && !flip[i]) begin
            db_nxt[i] = db_cnt[i] + DW'(1);
         end

         if (level[i]) begin
            hold_nxt[i] = (hold_cnt[i] == HW'(P_LONG_CYCLES)) ? hold_cnt[i]
                                                              : hold_cnt[i] + HW'(1);
         end

         case (state[i])
            IDLE: begin
               if (flip[i]) state_nxt[i] = HELD;
            end
            HELD: begin
               if (flip[i]) begin
                  state_nxt[i] = IDLE;
               end else if (hold_cnt[i] == HW'(P_LONG_CYCLES - 1)) begin
                  // Only reachable once per press: LONG never returns to HELD.
                  state_nxt[i] = LONG;
                  long_nxt[i]  = 1'b1;
               end
            end
            LONG: begin
               if (flip[i]) state_nxt[i] = IDLE;
            end
            default: state_nxt[i] = IDLE;
         endcase
      end
   end

   // State and datapath registers.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         sync1   <= '0;
         sync2   <= '0;
         level   <= '0;
         press_q <= '0;
         rel_q   <= '0;
         long_q  <= '0;
         for (int i = 0; i < int'(W); i++) begin
            db_cnt[i]   <= '0;
            hold_cnt[i] <= '0;
            state[i]    <= IDLE;
         end
      end else begin
         sync1   <= bus.iButtonRaw;
         sync2   <= sync1;
         level   <= level ^ flip;
         press_q <= flip & ~level;
         rel_q   <= flip & level;
         long_q  <= long_nxt;
         for (int i = 0; i < int'(W); i++) begin
            db_cnt[i]   <= db_nxt[i];
            hold_cnt[i] <= hold_nxt[i];
            state[i]    <= state_nxt[i];
         end
      end
   end

   assign bus.oButtonLevel   = level;
   assign bus.oButtonPress   = press_q;
   assign bus.oButtonRelease = rel_q;
   assign bus.oButtonLong    = long_q;

`ifdef BUTTON_DEBOUNCE_AUTOREPEAT_EN
   localparam int unsigned RW = $clog2(P_REPEAT_CYCLES + 1);

   logic [RW-1:0] rep_cnt [W];
   logic [RW-1:0] rep_nxt [W];
   logic [W-1:0]  rep_fire, rep_q;

   // Repeat period counter, running only in LONG; a release edge suppresses the pulse.
   always_comb begin
      rep_fire = '0;
      for (int i = 0; i < int'(W); i++) begin
         rep_nxt[i] = '0;
         if (state[i] == LONG && !flip[i]) begin
            if (rep_cnt[i] == RW'(P_REPEAT_CYCLES - 1)) begin
               rep_fire[i] = 1'b1;
            end else begin
               rep_nxt[i] = rep_cnt[i] + RW'(1);
            end
         end
      end
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         rep_q <= '0;
         for (int i = 0; i < int'(W); i++) rep_cnt[i] <= '0;
      end else begin
         rep_q <= rep_fire;
         for (int i = 0; i < int'(W); i++) rep_cnt[i] <= rep_nxt[i];
      end
   end

   assign bus.oButtonRepeat = rep_q;
`else
   assign bus.oButtonRepeat = '0;
`endif
endmodule

// File: tb/tb_button_debounce.sv
// tb_button_debounce: directed bench for button_debounce (W=5, D=4, LONG=20, REPEAT=8).
// Expected pulse/level events are queued when stimulus is driven and checked every cycle.
module tb_button_debounce;
   localparam int unsigned W      = 5;
   localparam int unsigned IW     = $clog2(W);
   localparam int unsigned D      = 4;
   localparam int unsigned LONG_C = 20;
   localparam int unsigned REP_C  = 8;
   localparam int          LAT    = int'(D) + 2;

   typedef enum int {K_PRESS, K_REL, K_LONG, K_REP, K_LSET, K_LCLR} kind_t;
   typedef struct {
      int    cyc;
      kind_t kind;
      int    ch;
   } ev_t;

   logic         clk = 1'b0;
   logic         rst;
   int           cyc = 0;
   int           vectors = 0;
   int           miscompares = 0;
   logic [W-1:0] exp_level;
   ev_t          sb[$];

   button_debounce_if #(.P_BUTTON_WIDTH(W)) bus ();

   button_debounce #(
      .P_BUTTON_WIDTH   (W),
      .P_DEBOUNCE_CYCLES(D),
      .P_LONG_CYCLES    (LONG_C),
      .P_REPEAT_CYCLES  (REP_C)
   ) dut (
      .iClk(clk),
      .iRst(rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic push(input int c, input kind_t k, input int ch);
      ev_t e;
      e.cyc  = c;
      e.kind = k;
      e.ch   = ch;
      sb.push_back(e);
   endtask

   // Queue the events of one clean press whose raw input rises in cycle t for n cycles.
   task automatic plan(input int ch, input int t, input int n);
      int p;
      p = t + LAT;
      push(p, K_PRESS, ch);
      push(p, K_LSET, ch);
      push(p + n, K_REL, ch);
      push(p + n, K_LCLR, ch);
      if (int'(LONG_C) < n) begin
         push(p + int'(LONG_C), K_LONG, ch);
`ifdef BUTTON_DEBOUNCE_AUTOREPEAT_EN
         for (int k = int'(LONG_C + REP_C); k < n; k += int'(REP_C)) push(p + k, K_REP, ch);
`endif
      end
   endtask

   task automatic cmp(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
      end
   endtask

   task automatic check();
      logic [W-1:0] e_press, e_rel, e_long, e_rep;
      e_press = '0;
      e_rel   = '0;
      e_long  = '0;
      e_rep   = '0;
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].cyc <= cyc) begin
            if (sb[i].cyc == cyc) begin
               case (sb[i].kind)
                  K_PRESS: e_press[IW'(sb[i].ch)]   = 1'b1;
                  K_REL:   e_rel[IW'(sb[i].ch)]     = 1'b1;
                  K_LONG:  e_long[IW'(sb[i].ch)]    = 1'b1;
                  K_REP:   e_rep[IW'(sb[i].ch)]     = 1'b1;
                  K_LSET:  exp_level[IW'(sb[i].ch)] = 1'b1;
                  K_LCLR:  exp_level[IW'(sb[i].ch)] = 1'b0;
                  default: ;
               endcase
            end
            sb.delete(i);
         end
      end
      cmp("level",   bus.oButtonLevel,   exp_level);
      cmp("press",   bus.oButtonPress,   e_press);
      cmp("release", bus.oButtonRelease, e_rel);
      cmp("long",    bus.oButtonLong,    e_long);
      cmp("repeat",  bus.oButtonRepeat,  e_rep);
   endtask

   task automatic step();
      @(posedge clk);
      cyc++;
      @(negedge clk);
      check();
   endtask

   task automatic set_raw(input int ch, input logic v);
      bus.iButtonRaw[IW'(ch)] = v;
   endtask

   initial begin
      rst            = 1'b1;
      bus.iButtonRaw = '0;
      exp_level      = '0;

      // Reset with all buttons released.
      repeat (4) step();
      rst = 1'b0;
      repeat (3) step();

      // Clean 10-cycle press on channel 0.
      plan(0, cyc, 10);
      set_raw(0, 1'b1);
      repeat (10) step();
      set_raw(0, 1'b0);
      repeat (20) step();

      // 3-cycle glitch on channel 2: nothing expected.
      set_raw(2, 1'b1);
      repeat (3) step();
      set_raw(2, 1'b0);
      repeat (12) step();

      // Bounce on channel 4 for 12 cycles, then a stable 15-cycle press.
      plan(4, cyc + 12, 15);
      for (int k = 0; k < 3; k++) begin
         set_raw(4, 1'b1);
         repeat (2) step();
         set_raw(4, 1'b0);
         repeat (2) step();
      end
      set_raw(4, 1'b1);
      repeat (15) step();
      set_raw(4, 1'b0);
      repeat (20) step();

      // Channel 1 held for 50 cycles: long press and repeats.
      plan(1, cyc, 50);
      set_raw(1, 1'b1);
      repeat (50) step();
      set_raw(1, 1'b0);
      repeat (20) step();

      // Channels 0 and 3 together, then reset while both are held.
      plan(0, cyc, 100);
      plan(3, cyc, 100);
      set_raw(0, 1'b1);
      set_raw(3, 1'b1);
      repeat (LAT + 5) step();
      rst = 1'b1;
      sb.delete();
      exp_level = '0;
      repeat (3) step();
      rst = 1'b0;
      plan(0, cyc, 12);
      plan(3, cyc, 12);
      repeat (12) step();
      set_raw(0, 1'b0);
      set_raw(3, 1'b0);
      repeat (20) step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
